// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: buffers one byte behind a valid/ready handshake and
// composes start, LSB-first data (from an external serializer), optional parity and stop bits.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  ready,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic                  stop2,
    input  logic                  ser_done,
    input  logic                  ser_data,
    output logic                  ser_en,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  tx_out,
    output logic                  busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_WIDTH-1:0] holding;
    logic                  holding_full;
    logic                  par_bit;
    logic                  cfg_par_en;
    logic                  cfg_stop2;
    logic                  stop_cnt;
    logic                  accept;
    logic                  start_entry;
    logic                  stop_last;

    assign ready       = ~holding_full;
    assign accept      = data_valid & ~holding_full;
    assign stop_last   = ~cfg_stop2 | stop_cnt;
    assign start_entry = (next_state == START);
    assign p_data      = holding;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ser_en <= 1'b0;
        end else begin
            state  <= next_state;
            ser_en <= (next_state == START) || (next_state == DATA);
        end
    end

    always_comb begin
        next_state = state;
        tx_out     = 1'b1;
        case (state)
            IDLE: begin
                if (holding_full) next_state = START;
            end
            START: begin
                tx_out     = 1'b0;
                next_state = DATA;
            end
            DATA: begin
                tx_out = ser_data;
                if (ser_done) next_state = cfg_par_en ? PARITY : STOP;
            end
            PARITY: begin
                tx_out     = par_bit;
                next_state = STOP;
            end
            STOP: begin
                if (stop_last) next_state = holding_full ? START : IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Parity type needs no register of its own: it is folded into par_bit at frame start.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            holding      <= '0;
            holding_full <= 1'b0;
            par_bit      <= 1'b0;
            cfg_par_en   <= 1'b0;
            cfg_stop2    <= 1'b0;
            stop_cnt     <= 1'b0;
        end else begin
            if (start_entry) begin
                holding_full <= 1'b0;
                par_bit      <= (^holding) ^ par_type;
                cfg_par_en   <= par_en;
                cfg_stop2    <= stop2;
            end else if (accept) begin
                holding      <= data_in;
                holding_full <= 1'b1;
            end
            stop_cnt <= (state == STOP) && !stop_last;
        end
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomized bench for uart_tx_ctrl: a behavioural serializer feeds the DUT, and a
// frame-level reference model predicts the line, handshake and serializer enable each cycle.
module tb_uart_tx_ctrl;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic       data_valid;
    logic       ready;
    logic       par_en;
    logic       par_type;
    logic       stop2;
    logic       ser_done;
    logic       ser_data;
    logic       ser_en;
    logic [7:0] p_data;
    logic       tx_out;
    logic       busy;

    int vec_count;
    int err_count;

    uart_tx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .data_valid (data_valid),
        .ready      (ready),
        .par_en     (par_en),
        .par_type   (par_type),
        .stop2      (stop2),
        .ser_done   (ser_done),
        .ser_data   (ser_data),
        .ser_en     (ser_en),
        .p_data     (p_data),
        .tx_out     (tx_out),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Serializer: loads while ser_en is low, presents bit0 in the first shift cycle.
    logic [7:0] ser_sh;
    logic [3:0] ser_cnt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ser_sh  <= 8'h00;
            ser_cnt <= 4'd0;
        end else if (!ser_en) begin
            ser_sh  <= p_data;
            ser_cnt <= 4'd0;
        end else begin
            if (ser_cnt != 4'd0) ser_sh <= ser_sh >> 1;
            if (ser_cnt != 4'd8) ser_cnt <= ser_cnt + 4'd1;
        end
    end

    assign ser_data = ser_sh[0];
    assign ser_done = ser_en && (ser_cnt == 4'd8);

    // Reference model: the whole frame as a bit list plus a one-byte pending slot.
    bit       m_frame[$];
    int       m_pos;
    bit       m_active;
    bit       m_pend;
    bit [7:0] m_hold;

    function automatic void modelReset();
        m_frame.delete();
        m_pos    = 0;
        m_active = 1'b0;
        m_pend   = 1'b0;
        m_hold   = 8'h00;
    endfunction

    function automatic void buildFrame(input bit [7:0] d, input bit pe, input bit pt, input bit s2);
        bit odd_ones;
        m_frame.delete();
        m_frame.push_back(1'b0);
        for (int i = 0; i < 8; i++) m_frame.push_back(d[i]);
        odd_ones = ($countones(d) % 2) == 1;
        if (pe) m_frame.push_back(odd_ones ^ pt);
        m_frame.push_back(1'b1);
        if (s2) m_frame.push_back(1'b1);
    endfunction

    function automatic void modelEdge();
        bit acc;
        acc = data_valid && !m_pend;
        if (m_active) begin
            m_pos++;
            if (m_pos == m_frame.size()) m_active = 1'b0;
        end
        if (!m_active && m_pend) begin
            buildFrame(m_hold, par_en, par_type, stop2);
            m_pos    = 0;
            m_active = 1'b1;
            m_pend   = 1'b0;
        end
        if (acc) begin
            m_pend = 1'b1;
            m_hold = data_in;
        end
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vec_count++;
        if (obs !== exp) begin
            err_count++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic compareAll();
        logic exp_tx;
        exp_tx = m_active ? m_frame[m_pos] : 1'b1;
        checkOutput("tx_out", {7'd0, tx_out}, {7'd0, exp_tx});
        checkOutput("busy",   {7'd0, busy},   {7'd0, m_active});
        checkOutput("ready",  {7'd0, ready},  {7'd0, !m_pend});
        checkOutput("ser_en", {7'd0, ser_en}, {7'd0, (m_active && m_pos < 9)});
        checkOutput("p_data", p_data, m_hold);
    endtask

    task automatic applyStimulus(input logic [7:0] din, input logic dv, input logic pe,
                                 input logic pt, input logic s2, input logic r);
        @(negedge clk);
        data_in    = din;
        data_valid = dv;
        par_en     = pe;
        par_type   = pt;
        stop2      = s2;
        rst        = r;
        if (!r) modelReset();
        #1;
        compareAll();
        @(posedge clk);
        if (rst) modelEdge();
    endtask

    task automatic idleCycles(input int n, input logic pe, input logic pt, input logic s2);
        for (int i = 0; i < n; i++) applyStimulus(8'h00, 1'b0, pe, pt, s2, 1'b1);
    endtask

    initial begin
        vec_count  = 0;
        err_count  = 0;
        rst        = 1'b0;
        data_in    = 8'h00;
        data_valid = 1'b0;
        par_en     = 1'b0;
        par_type   = 1'b0;
        stop2      = 1'b0;
        modelReset();

        #2;
        checkOutput("reset_tx",     {7'd0, tx_out}, 8'h01);
        checkOutput("reset_busy",   {7'd0, busy},   8'h00);
        checkOutput("reset_ready",  {7'd0, ready},  8'h01);
        checkOutput("reset_ser_en", {7'd0, ser_en}, 8'h00);
        checkOutput("reset_p_data", p_data,         8'h00);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles(2, 1'b0, 1'b0, 1'b0);

        // Single frames with different configurations; config toggles mid-frame.
        applyStimulus(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idleCycles(13, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h01, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        applyStimulus(8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
        idleCycles(4, 1'b0, 1'b0, 1'b0);
        idleCycles(9, 1'b1, 1'b0, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idleCycles(12, 1'b0, 1'b0, 1'b0);

        // Back-to-back: second byte offered during the first frame's data phase.
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idleCycles(5, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        idleCycles(22, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of the data phase, then a clean frame.
        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        idleCycles(5, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        idleCycles(13, 1'b0, 1'b0, 1'b0);

        // Valid held while the holding register is full: new byte must wait.
        applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'h22, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        applyStimulus(8'h33, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        idleCycles(26, 1'b0, 1'b0, 1'b0);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 4000; i++) begin
            applyStimulus(8'($urandom_range(0, 255)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 399) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
